// File: rtl/jtpang_sdram_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : jtpang_sdram_arb_if
// Description : Bundle of ROM-bank read ports, download write port and
//               SDRAM engine command/return signals around the arbiter.
//               master = arbiter side, slave = surrounding logic/engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtpang_sdram_arb_if #(
  parameter int AW = 22
);
  // bank read ports
  logic          downloading;
  logic [3:0]    ba_rd;
  logic [AW-1:0] ba0_addr;
  logic [AW-1:0] ba1_addr;
  logic [AW-1:0] ba2_addr;
  logic [AW-1:0] ba3_addr;
  logic [3:0]    ba_ack;
  logic [3:0]    ba_dst;
  logic [3:0]    ba_rdy;
  logic [15:0]   data_read;
  // download write port
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [1:0]    prog_ba;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_ack;
  logic          prog_rdy;
  // engine side
  logic          cmd_req;
  logic          cmd_wr;
  logic [1:0]    cmd_ba;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   cmd_din;
  logic [1:0]    cmd_mask;
  logic          cmd_ack;
  logic          rd_dst;
  logic          rd_rdy;
  logic [15:0]   sdram_dout;
  logic          err;

  modport master (
    input  downloading, ba_rd, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
           prog_we, prog_addr, prog_ba, prog_data, prog_mask,
           cmd_ack, rd_dst, rd_rdy, sdram_dout,
    output ba_ack, ba_dst, ba_rdy, data_read, prog_ack, prog_rdy,
           cmd_req, cmd_wr, cmd_ba, cmd_addr, cmd_din, cmd_mask, err
  );

  modport slave (
    output downloading, ba_rd, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
           prog_we, prog_addr, prog_ba, prog_data, prog_mask,
           cmd_ack, rd_dst, rd_rdy, sdram_dout,
    input  ba_ack, ba_dst, ba_rdy, data_read, prog_ack, prog_rdy,
           cmd_req, cmd_wr, cmd_ba, cmd_addr, cmd_din, cmd_mask, err
  );
endinterface
`default_nettype wire

// File: rtl/jtpang_sdram_arb.sv
`default_nettype none
// ============================================================================
// Module      : jtpang_sdram_arb
// Description : Round-robin arbiter of four ROM bank reads plus an exclusive
//               download write port onto a single-command SDRAM engine.
//               An owner-tag FIFO routes returned bursts to the issuing bank.
// Revision    : 1.0 - initial release
// ============================================================================
module jtpang_sdram_arb #(
  parameter int AW     = 22,
  parameter int QDEPTH = 2    // power of two, at least 2
) (
  input  logic               clk,
  input  logic               rst_n,
  jtpang_sdram_arb_if.master bus
);

  localparam int c_PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int c_CW = $clog2(QDEPTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_rr;
  logic [1:0]      r_grant;
  logic            r_wr;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_din;
  logic [1:0]      r_mask;
  logic [3:0]      r_ba_ack;
  logic [3:0]      r_ba_dst;
  logic [3:0]      r_ba_rdy;
  logic [15:0]     r_data;
  logic            r_prog_ack;
  logic            r_prog_rdy;
  logic            r_err;
  logic [1:0]      r_fifo [QDEPTH];
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_CW-1:0] r_cnt;

  logic [1:0]      w_sel;
  logic            w_sel_vld;
  logic            w_load_wr;
  logic            w_load_rd;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [1:0]      w_head;
  logic [AW-1:0]   w_ba_addr [4];

  assign w_ba_addr[0] = bus.ba0_addr;
  assign w_ba_addr[1] = bus.ba1_addr;
  assign w_ba_addr[2] = bus.ba2_addr;
  assign w_ba_addr[3] = bus.ba3_addr;

  assign w_full  = (r_cnt == c_CW'(QDEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rptr];
  // only reads occupy a FIFO slot; writes return nothing
  assign w_push  = w_accept && !r_wr;
  assign w_pop   = bus.rd_rdy && !w_empty;

  // first requesting bank at or after the RR pointer; descending scan so the
  // smallest offset is the last (winning) assignment
  always_comb begin
    w_sel     = r_rr;
    w_sel_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.ba_rd[r_rr + 2'(i)]) begin
        w_sel     = r_rr + 2'(i);
        w_sel_vld = 1'b1;
      end
    end
  end

  // state register; async reset drops cmd_req immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state and load/accept strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load_wr   = 1'b0;
    w_load_rd   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.downloading && bus.prog_we) begin
          w_load_wr   = 1'b1;
          w_state_nxt = ST_REQ;
        end else if (!bus.downloading && w_sel_vld && !w_full) begin
          w_load_rd   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.cmd_ack) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // latch the granted command fields when leaving IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_grant <= '0;
      r_din   <= '0;
      r_mask  <= '0;
    end else if (w_load_wr) begin
      r_wr    <= 1'b1;
      r_addr  <= bus.prog_addr;
      r_grant <= bus.prog_ba;
      r_din   <= bus.prog_data;
      r_mask  <= bus.prog_mask;
    end else if (w_load_rd) begin
      r_wr    <= 1'b0;
      r_addr  <= w_ba_addr[w_sel];
      r_grant <= w_sel;
    end
  end

  // acknowledge pulses, RR pointer advance and owner-tag FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ba_ack   <= '0;
      r_prog_ack <= 1'b0;
      r_prog_rdy <= 1'b0;
      r_rr       <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < QDEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_ba_ack   <= '0;
      r_prog_ack <= w_accept && r_wr;
      r_prog_rdy <= r_prog_ack;
      if (w_push) begin
        r_ba_ack       <= 4'b0001 << r_grant;
        r_rr           <= r_grant + 2'd1;
        r_fifo[r_wptr] <= r_grant;
        r_wptr         <= r_wptr + c_PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + c_PW'(1);
      r_cnt <= r_cnt + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  // route returned burst markers to the FIFO head owner; stray ones flag err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ba_dst <= '0;
      r_ba_rdy <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_ba_dst <= '0;
      r_ba_rdy <= '0;
      r_data   <= bus.sdram_dout;
      if (!w_empty) begin
        if (bus.rd_dst) r_ba_dst <= 4'b0001 << w_head;
        if (bus.rd_rdy) r_ba_rdy <= 4'b0001 << w_head;
      end else if (bus.rd_dst || bus.rd_rdy) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.cmd_req   = (r_state == ST_REQ);
  assign bus.cmd_wr    = r_wr;
  assign bus.cmd_ba    = r_grant;
  assign bus.cmd_addr  = r_addr;
  assign bus.cmd_din   = r_din;
  assign bus.cmd_mask  = r_mask;
  assign bus.ba_ack    = r_ba_ack;
  assign bus.ba_dst    = r_ba_dst;
  assign bus.ba_rdy    = r_ba_rdy;
  assign bus.data_read = r_data;
  assign bus.prog_ack  = r_prog_ack;
  assign bus.prog_rdy  = r_prog_rdy;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_jtpang_sdram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtpang_sdram_arb
// Description : Self-checking bench for jtpang_sdram_arb; the bench plays the
//               SDRAM engine and keeps a queue of expected burst owners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtpang_sdram_arb;
  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  jtpang_sdram_arb_if #(.AW(AW)) bus ();

  jtpang_sdram_arb #(.AW(AW), .QDEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.downloading = 1'b0; bus.ba_rd = '0;
    bus.ba0_addr = '0; bus.ba1_addr = '0; bus.ba2_addr = '0; bus.ba3_addr = '0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_ba = '0;
    bus.prog_data = '0; bus.prog_mask = '0;
    bus.cmd_ack = 1'b0; bus.rd_dst = 1'b0; bus.rd_rdy = 1'b0; bus.sdram_dout = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // wait (bounded) for the engine-side command request
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cmd_req) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [80:0] outs;
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    outs = {bus.ba_ack, bus.ba_dst, bus.ba_rdy, bus.data_read, bus.prog_ack, bus.prog_rdy,
            bus.cmd_req, bus.cmd_wr, bus.cmd_ba, bus.cmd_addr, bus.cmd_din, bus.cmd_mask, bus.err};
    vectors++; if (outs !== '0) begin miscompares++; $display("FAIL reset_outputs got %0h want 0", outs); end
    rst_n = 1'b1;
    tick();
    vectors++; if (bus.cmd_req !== 1'b0) begin miscompares++; $display("FAIL reset_idle cmd_req got %0b want 0", bus.cmd_req); end
  endtask

  task automatic test_single_read();
    bit ok; int e;
    do_reset();
    bus.ba2_addr = 22'h12345; bus.ba_rd = 4'b0100;
    wait_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL t1_req_timeout got 0 want 1"); end
    vectors++; if (bus.cmd_ba !== 2'd2) begin miscompares++; $display("FAIL t1_cmd_ba got %0h want 2", bus.cmd_ba); end
    vectors++; if (bus.cmd_addr !== 22'h12345) begin miscompares++; $display("FAIL t1_cmd_addr got %0h want 12345", bus.cmd_addr); end
    vectors++; if (bus.cmd_wr !== 1'b0) begin miscompares++; $display("FAIL t1_cmd_wr got %0b want 0", bus.cmd_wr); end
    repeat (3) tick();
    vectors++; if ({bus.cmd_req, bus.ba_ack} !== 5'b1_0000) begin miscompares++; $display("FAIL t1_hold got %0h want 10", {bus.cmd_req, bus.ba_ack}); end
    bus.cmd_ack = 1'b1; exp_q.push_back(2);
    tick();
    bus.cmd_ack = 1'b0; bus.ba_rd = '0;
    vectors++; if ({bus.cmd_req, bus.ba_ack} !== 5'b0_0100) begin miscompares++; $display("FAIL t1_ack got %0h want 04", {bus.cmd_req, bus.ba_ack}); end
    tick();
    vectors++; if (bus.ba_ack !== 4'b0000) begin miscompares++; $display("FAIL t1_ack_pulse got %0h want 0", bus.ba_ack); end
    bus.rd_dst = 1'b1; bus.sdram_dout = 16'hA5A5;
    tick();
    bus.rd_dst = 1'b0;
    vectors++; if (bus.ba_dst !== 4'(1 << exp_q[0])) begin miscompares++; $display("FAIL t1_dst got %0h want %0h", bus.ba_dst, 4'(1 << exp_q[0])); end
    vectors++; if (bus.data_read !== 16'hA5A5) begin miscompares++; $display("FAIL t1_data0 got %0h want a5a5", bus.data_read); end
    bus.rd_rdy = 1'b1; bus.sdram_dout = 16'h5A5A;
    tick();
    bus.rd_rdy = 1'b0;
    e = exp_q.pop_front();
    vectors++; if ({bus.ba_rdy, bus.ba_dst} !== {4'(1 << e), 4'b0000}) begin miscompares++; $display("FAIL t1_rdy got %0h want %0h", {bus.ba_rdy, bus.ba_dst}, {4'(1 << e), 4'b0000}); end
    vectors++; if (bus.data_read !== 16'h5A5A) begin miscompares++; $display("FAIL t1_data1 got %0h want 5a5a", bus.data_read); end
    tick();
    vectors++; if ({bus.ba_rdy, bus.err} !== 5'b0) begin miscompares++; $display("FAIL t1_idle got %0h want 0", {bus.ba_rdy, bus.err}); end
  endtask

  task automatic test_round_robin();
    bit ok; int e; int x;
    do_reset();
    bus.ba_rd = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      x = n % 4;
      wait_req(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL t2_req_timeout n=%0d got 0 want 1", n); end
      vectors++; if (bus.cmd_ba !== 2'(x)) begin miscompares++; $display("FAIL t2_grant n=%0d got %0d want %0d", n, bus.cmd_ba, x); end
      bus.cmd_ack = 1'b1; exp_q.push_back(x);
      tick();
      bus.cmd_ack = 1'b0;
      vectors++; if (bus.ba_ack !== 4'(1 << x)) begin miscompares++; $display("FAIL t2_ack n=%0d got %0h want %0h", n, bus.ba_ack, 4'(1 << x)); end
      bus.rd_rdy = 1'b1;
      tick();
      bus.rd_rdy = 1'b0;
      e = exp_q.pop_front();
      vectors++; if ({bus.ba_rdy, bus.ba_ack} !== {4'(1 << e), 4'b0000}) begin miscompares++; $display("FAIL t2_rdy n=%0d got %0h want %0h", n, {bus.ba_rdy, bus.ba_ack}, {4'(1 << e), 4'b0000}); end
    end
    bus.ba_rd = '0;
  endtask

  task automatic test_fifo_full();
    bit ok; bit seen; int e;
    do_reset();
    bus.ba_rd = 4'b0011;
    for (int n = 0; n < 2; n++) begin
      wait_req(ok);
      vectors++; if (!ok || bus.cmd_ba !== 2'(n)) begin miscompares++; $display("FAIL t3_grant n=%0d got %0d want %0d", n, bus.cmd_ba, n); end
      bus.cmd_ack = 1'b1; exp_q.push_back(n);
      tick();
      bus.cmd_ack = 1'b0;
      vectors++; if (bus.ba_ack !== 4'(1 << n)) begin miscompares++; $display("FAIL t3_ack n=%0d got %0h want %0h", n, bus.ba_ack, 4'(1 << n)); end
    end
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (bus.cmd_req || bus.ba_ack != 4'b0) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL t3_full_block got 1 want 0"); end
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0;
    e = exp_q.pop_front();
    vectors++; if (bus.ba_rdy !== 4'(1 << e)) begin miscompares++; $display("FAIL t3_pop got %0h want %0h", bus.ba_rdy, 4'(1 << e)); end
    wait_req(ok);
    vectors++; if (!ok || bus.cmd_ba !== 2'd0) begin miscompares++; $display("FAIL t3_third got %0d/%0b want 0/1", bus.cmd_ba, ok); end
    bus.cmd_ack = 1'b1; exp_q.push_back(0);
    tick();
    bus.cmd_ack = 1'b0; bus.ba_rd = '0;
    vectors++; if (bus.ba_ack !== 4'b0001) begin miscompares++; $display("FAIL t3_third_ack got %0h want 1", bus.ba_ack); end
    repeat (2) begin
      bus.rd_rdy = 1'b1;
      tick();
      bus.rd_rdy = 1'b0;
      e = exp_q.pop_front();
      vectors++; if (bus.ba_rdy !== 4'(1 << e)) begin miscompares++; $display("FAIL t3_drain got %0h want %0h", bus.ba_rdy, 4'(1 << e)); end
    end
  endtask

  task automatic test_download();
    bit ok; bit seen; int e;
    do_reset();
    bus.downloading = 1'b1; bus.ba_rd = 4'b0001; bus.ba0_addr = 22'h00ABC;
    bus.prog_we = 1'b1; bus.prog_addr = 22'h100; bus.prog_ba = 2'd1;
    bus.prog_data = 16'hBEEF; bus.prog_mask = 2'b10;
    wait_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL t4_req_timeout got 0 want 1"); end
    vectors++; if ({bus.cmd_wr, bus.cmd_ba, bus.cmd_addr, bus.cmd_din, bus.cmd_mask} !== {1'b1, 2'd1, 22'h100, 16'hBEEF, 2'b10})
      begin miscompares++; $display("FAIL t4_wr_fields got %0h want %0h", {bus.cmd_wr, bus.cmd_ba, bus.cmd_addr, bus.cmd_din, bus.cmd_mask}, {1'b1, 2'd1, 22'h100, 16'hBEEF, 2'b10}); end
    bus.cmd_ack = 1'b1;
    tick();
    bus.cmd_ack = 1'b0; bus.prog_we = 1'b0;
    vectors++; if ({bus.prog_ack, bus.prog_rdy, bus.ba_ack} !== 6'b10_0000) begin miscompares++; $display("FAIL t4_prog_ack got %0h want 20", {bus.prog_ack, bus.prog_rdy, bus.ba_ack}); end
    tick();
    vectors++; if ({bus.prog_ack, bus.prog_rdy} !== 2'b01) begin miscompares++; $display("FAIL t4_prog_rdy got %0b want 01", {bus.prog_ack, bus.prog_rdy}); end
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (bus.cmd_req || bus.ba_ack != 4'b0) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL t4_bank_held got 1 want 0"); end
    bus.downloading = 1'b0;
    wait_req(ok);
    vectors++; if (!ok || {bus.cmd_wr, bus.cmd_ba, bus.cmd_addr} !== {1'b0, 2'd0, 22'h00ABC}) begin miscompares++; $display("FAIL t4_read_after got %0h want abc", {bus.cmd_wr, bus.cmd_ba, bus.cmd_addr}); end
    bus.cmd_ack = 1'b1; exp_q.push_back(0);
    tick();
    bus.cmd_ack = 1'b0; bus.ba_rd = '0;
    vectors++; if (bus.ba_ack !== 4'b0001) begin miscompares++; $display("FAIL t4_ba_ack got %0h want 1", bus.ba_ack); end
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0;
    e = exp_q.pop_front();
    vectors++; if (bus.ba_rdy !== 4'(1 << e)) begin miscompares++; $display("FAIL t4_rdy got %0h want %0h", bus.ba_rdy, 4'(1 << e)); end
  endtask

  task automatic test_push_pop();
    bit ok; int e;
    do_reset();
    bus.ba_rd = 4'b0010;
    wait_req(ok);
    vectors++; if (!ok || bus.cmd_ba !== 2'd1) begin miscompares++; $display("FAIL t5_first got %0d want 1", bus.cmd_ba); end
    bus.cmd_ack = 1'b1; exp_q.push_back(1);
    tick();
    bus.cmd_ack = 1'b0; bus.ba_rd = 4'b1000;
    wait_req(ok);
    vectors++; if (!ok || bus.cmd_ba !== 2'd3) begin miscompares++; $display("FAIL t5_second got %0d want 3", bus.cmd_ba); end
    bus.cmd_ack = 1'b1; bus.rd_rdy = 1'b1; exp_q.push_back(3);
    tick();
    bus.cmd_ack = 1'b0; bus.rd_rdy = 1'b0; bus.ba_rd = '0;
    e = exp_q.pop_front();
    vectors++; if ({bus.ba_rdy, bus.ba_ack} !== {4'(1 << e), 4'b1000}) begin miscompares++; $display("FAIL t5_same_cycle got %0h want %0h", {bus.ba_rdy, bus.ba_ack}, {4'(1 << e), 4'b1000}); end
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0;
    e = exp_q.pop_front();
    vectors++; if ({bus.ba_rdy, bus.err} !== {4'(1 << e), 1'b0}) begin miscompares++; $display("FAIL t5_route got %0h want %0h", {bus.ba_rdy, bus.err}, {4'(1 << e), 1'b0}); end
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0;
    vectors++; if ({bus.ba_rdy, bus.err} !== 5'b0000_1) begin miscompares++; $display("FAIL t5_only_one got %0h want 01", {bus.ba_rdy, bus.err}); end
  endtask

  task automatic test_err_reset();
    bit ok; logic [80:0] outs;
    do_reset();
    bus.rd_dst = 1'b1;
    tick();
    bus.rd_dst = 1'b0;
    vectors++; if ({bus.ba_dst, bus.err} !== 5'b0000_1) begin miscompares++; $display("FAIL t6_stray got %0h want 01", {bus.ba_dst, bus.err}); end
    tick(); tick();
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL t6_sticky got %0b want 1", bus.err); end
    bus.ba_rd = 4'b0001;
    wait_req(ok);
    bus.cmd_ack = 1'b1;
    tick();
    bus.cmd_ack = 1'b0; bus.ba_rd = 4'b0100;
    wait_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL t6_req_timeout got 0 want 1"); end
    #2;
    rst_n = 1'b0;
    bus.ba_rd = '0;
    #1;
    outs = {bus.ba_ack, bus.ba_dst, bus.ba_rdy, bus.data_read, bus.prog_ack, bus.prog_rdy,
            bus.cmd_req, bus.cmd_wr, bus.cmd_ba, bus.cmd_addr, bus.cmd_din, bus.cmd_mask, bus.err};
    vectors++; if (outs !== '0) begin miscompares++; $display("FAIL t6_async_reset got %0h want 0", outs); end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0;
    vectors++; if ({bus.ba_rdy, bus.err} !== 5'b0000_1) begin miscompares++; $display("FAIL t6_flushed got %0h want 01", {bus.ba_rdy, bus.err}); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fifo_full();
    test_download();
    test_push_pop();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
